// File: rtl/regfile_sb.sv
// Integer register file with a pending-write scoreboard. Writeback feeds the write
// port, decode reads two registered operands and is stalled on outstanding writes.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int REGNUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phase_decode,
    input  logic              phase_writeback,
    input  logic              flush,
    input  logic [4:0]        rs1sel_dr,
    input  logic [4:0]        rs2sel_dr,
    input  logic              issue_valid_dr,
    input  logic [4:0]        issue_rd_dr,
    input  logic [4:0]        rdsel_wr,
    input  logic [XLEN-1:0]   rddata_wr,
    output logic [XLEN-1:0]   rs1data_rd,
    output logic [XLEN-1:0]   rs2data_rd,
    output logic              stall_decode,
    output logic [REGNUM-1:0] busy_vec
);

    logic [XLEN-1:0]   regs [REGNUM];
    logic [REGNUM-1:0] busy_next;
    logic [XLEN-1:0]   rs1_next;
    logic [XLEN-1:0]   rs2_next;
    logic              wb_write;
    logic              rs1_hit_wb;
    logic              rs2_hit_wb;
    logic              rs1_hazard;
    logic              rs2_hazard;
    logic              decode_fire;
    logic              issue_fire;

    assign wb_write   = phase_writeback && (rdsel_wr != 5'd0);
    assign rs1_hit_wb = phase_writeback && (rdsel_wr == rs1sel_dr);
    assign rs2_hit_wb = phase_writeback && (rdsel_wr == rs2sel_dr);

    // A writeback landing this cycle resolves the hazard through the bypass path.
    assign rs1_hazard = (rs1sel_dr != 5'd0) && busy_vec[rs1sel_dr] && !rs1_hit_wb;
    assign rs2_hazard = (rs2sel_dr != 5'd0) && busy_vec[rs2sel_dr] && !rs2_hit_wb;

    assign stall_decode = phase_decode && !flush && (rs1_hazard || rs2_hazard);
    assign decode_fire  = phase_decode && !stall_decode;
    assign issue_fire   = decode_fire && issue_valid_dr;

    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the combinational block infers a latch.
    always_comb begin
        rs1_next = regs[rs1sel_dr];
        rs2_next = regs[rs2sel_dr];
        if (rs1sel_dr == 5'd0) begin
            rs1_next = '0;
        end else if (rs1_hit_wb) begin
            rs1_next = rddata_wr;
        end
        if (rs2sel_dr == 5'd0) begin
            rs2_next = '0;
        end else if (rs2_hit_wb) begin
            rs2_next = rddata_wr;
        end
    end

    // Set is applied after clear so a new producer keeps the bit pending (WAW).
    always_comb begin
        busy_next = busy_vec;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (phase_writeback) begin
                busy_next[rdsel_wr] = 1'b0;
            end
            if (issue_fire) begin
                busy_next[issue_rd_dr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: the register array sits in the async reset domain because every
    // architectural register must read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGNUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops sample pre-edge values regardless of statement order.
            regs[rdsel_wr] <= rddata_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1data_rd <= '0;
            rs2data_rd <= '0;
            busy_vec   <= '0;
        end else begin
            busy_vec <= busy_next;
            if (decode_fire) begin
                rs1data_rd <= rs1_next;
                rs2data_rd <= rs2_next;
            end
        end
    end

endmodule
